// File: rtl/alu_op_sequencer.sv
// Execute-stage ALU sequencer: single-cycle add/sub/and/or/slt plus a multi-cycle
// shift-add MUL that stalls the pipeline until its registered result is ready.
module alu_op_sequencer #(
   parameter int unsigned inst_SIZE = 16,
   parameter int unsigned CNT_W     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [2:0]           ALU_ctrl,
   input  logic [inst_SIZE-1:0] in0,
   input  logic [inst_SIZE-1:0] in1,
   output logic                 ready,
   output logic                 stall,
   output logic                 done,
   output logic [inst_SIZE-1:0] ALU_output,
   output logic                 zero,
   output logic                 ovf,
   output logic                 illegal
);

   typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

   localparam logic [CNT_W-1:0] LastStep = CNT_W'(inst_SIZE - 1);
   localparam int unsigned      Msb      = inst_SIZE - 1;

   state_e               state_q, state_d;
   logic [inst_SIZE-1:0] mcand_q, mcand_d;
   logic [inst_SIZE-1:0] mplier_q, mplier_d;
   logic [inst_SIZE-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [inst_SIZE-1:0] res_q, res_d;
   logic                 zero_q, zero_d;
   logic                 ovf_q, ovf_d;
   logic                 ill_q, ill_d;

   logic [inst_SIZE-1:0] sum, diff, alu_res, acc_step;
   logic                 alu_ovf, alu_ill;

   assign sum      = in0 + in1;
   assign diff     = in0 - in1;
   assign acc_step = mcand_q[0] ? (acc_q + mplier_q) : acc_q;

   // Single-cycle result straight from the live operands on the accepting edge.
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_ill = 1'b0;
      case (ALU_ctrl)
         3'b000: begin
            alu_res = sum;
            alu_ovf = (in0[Msb] == in1[Msb]) && (sum[Msb] != in0[Msb]);
         end
         3'b001: begin
            alu_res = diff;
            alu_ovf = (in0[Msb] != in1[Msb]) && (diff[Msb] != in0[Msb]);
         end
         3'b010: alu_res = in0 & in1;
         3'b011: alu_res = in0 | in1;
         3'b100: alu_res = {{(inst_SIZE-1){1'b0}}, ($signed(in0) < $signed(in1))};
         3'b111: alu_res = '0;
         default: alu_ill = 1'b1;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      ill_d    = ill_q;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               mcand_d  = in0;
               mplier_d = in1;
               if (ALU_ctrl == 3'b111) begin
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = StMul;
               end else begin
                  res_d   = alu_res;
                  zero_d  = (alu_res == '0);
                  ovf_d   = alu_ovf;
                  ill_d   = alu_ill;
                  state_d = StDone;
               end
            end else begin
               state_d = StIdle;
            end
         end
         StMul: begin
            acc_d    = acc_step;
            mplier_d = mplier_q << 1;
            mcand_d  = mcand_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LastStep) begin
               res_d   = acc_step;
               zero_d  = (acc_step == '0);
               ovf_d   = 1'b0;
               ill_d   = 1'b0;
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         res_q    <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         ill_q    <= ill_d;
      end
   end

   assign ready      = (state_q == StIdle) || (state_q == StDone);
   assign stall      = (state_q == StMul);
   assign done       = (state_q == StDone);
   assign ALU_output = res_q;
   assign zero       = zero_q;
   assign ovf        = ovf_q;
   assign illegal    = ill_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed cases with literal results, then random traffic
// compared every cycle against a transaction-level model (countdown + integer arithmetic).
module tb_alu_op_sequencer;

   typedef struct packed {
      logic        ill;
      logic        ovf;
      logic [15:0] res;
   } alu_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  ALU_ctrl = 3'b000;
   logic [15:0] in0 = '0;
   logic [15:0] in1 = '0;
   logic        ready, stall, done, zero, ovf, illegal;
   logic [15:0] ALU_output;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   // Model state: remaining MUL cycles and the expected visible outputs.
   int          m_busy = 0;
   logic [15:0] m_prod = '0;
   logic        e_ready = 1'b1, e_stall = 1'b0, e_done = 1'b0;
   logic        e_zero = 1'b0, e_ovf = 1'b0, e_ill = 1'b0;
   logic [15:0] e_out = '0;

   alu_op_sequencer #(.inst_SIZE(16), .CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .ALU_ctrl   (ALU_ctrl),
      .in0        (in0),
      .in1        (in1),
      .ready      (ready),
      .stall      (stall),
      .done       (done),
      .ALU_output (ALU_output),
      .zero       (zero),
      .ovf        (ovf),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   function automatic alu_t ref_alu(input logic [2:0] op, input logic [15:0] a,
                                    input logic [15:0] b);
      alu_t r;
      int   sa, sb, s;
      sa = int'($signed(a));
      sb = int'($signed(b));
      r  = '0;
      case (op)
         3'd0: begin s = sa + sb; r.res = s[15:0]; r.ovf = (s > 32767) || (s < -32768); end
         3'd1: begin s = sa - sb; r.res = s[15:0]; r.ovf = (s > 32767) || (s < -32768); end
         3'd2: r.res = a & b;
         3'd3: r.res = a | b;
         3'd4: r.res = (sa < sb) ? 16'd1 : 16'd0;
         default: r.ill = 1'b1;
      endcase
      return r;
   endfunction

   function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      longint p;
      p = longint'(a) * longint'(b);
      return p[15:0];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy  <= 0;
         e_ready <= 1'b1; e_stall <= 1'b0; e_done <= 1'b0;
         e_out   <= '0;   e_zero  <= 1'b0; e_ovf  <= 1'b0; e_ill <= 1'b0;
      end else if (m_busy == 1) begin
         m_busy  <= 0;
         e_done  <= 1'b1; e_ready <= 1'b1; e_stall <= 1'b0;
         e_out   <= m_prod; e_zero <= (m_prod == 16'h0); e_ovf <= 1'b0; e_ill <= 1'b0;
      end else if (m_busy > 1) begin
         m_busy <= m_busy - 1;
         e_done <= 1'b0;
      end else begin
         e_done  <= 1'b0;
         e_stall <= 1'b0;
         e_ready <= 1'b1;
         if (start) begin
            if (ALU_ctrl == 3'd7) begin
               m_busy  <= 16;
               m_prod  <= ref_mul(in0, in1);
               e_stall <= 1'b1;
               e_ready <= 1'b0;
            end else begin
               e_done <= 1'b1;
               e_out  <= ref_alu(ALU_ctrl, in0, in1).res;
               e_zero <= (ref_alu(ALU_ctrl, in0, in1).res == 16'h0);
               e_ovf  <= ref_alu(ALU_ctrl, in0, in1).ovf;
               e_ill  <= ref_alu(ALU_ctrl, in0, in1).ill;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("ready", 32'(ready), 32'(e_ready));
         chk("stall", 32'(stall), 32'(e_stall));
         chk("done", 32'(done), 32'(e_done));
         chk("ALU_output", 32'(ALU_output), 32'(e_out));
         chk("zero", 32'(zero), 32'(e_zero));
         chk("ovf", 32'(ovf), 32'(e_ovf));
         chk("illegal", 32'(illegal), 32'(e_ill));
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   // Present one request for a single edge; returns 1ns after that edge.
   task automatic op1(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      start    = 1'b1;
      ALU_ctrl = op;
      in0      = a;
      in1      = b;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 5))
         0: return 16'h0000;
         1: return 16'h7FFF;
         2: return 16'h8000;
         3: return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_out", 32'(ALU_output), 32'd0);
      cyc();
      rst    = 1'b0;
      chk_on = 1'b1;

      cyc(); op1(3'd0, 16'h7FFF, 16'h0001);
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_out", 32'(ALU_output), 32'h8000);
      chk("t1_ovf", 32'(ovf), 32'd1);
      chk("t1_zero", 32'(zero), 32'd0);

      cyc(); op1(3'd1, 16'h1234, 16'h1234);
      chk("t2_out", 32'(ALU_output), 32'h0);
      chk("t2_zero", 32'(zero), 32'd1);
      chk("t2_ovf", 32'(ovf), 32'd0);
      cyc(); op1(3'd4, 16'hFFFF, 16'h0001);
      chk("t2_slt", 32'(ALU_output), 32'h1);

      cyc(); op1(3'd7, 16'h0123, 16'h0045);
      for (int k = 1; k <= 16; k++) begin
         chk("t3_stall", 32'(stall), 32'd1);
         chk("t3_nodone", 32'(done), 32'd0);
         if (k == 8) begin
            start = 1'b1; ALU_ctrl = 3'd0; in0 = 16'h0001; in1 = 16'h0001;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         in0   = 16'($urandom);
         in1   = 16'($urandom);
      end
      chk("t3_done", 32'(done), 32'd1);
      chk("t3_out", 32'(ALU_output), 32'h4E6F);
      @(posedge clk);
      #1;
      chk("t3_single_done", 32'(done), 32'd0);

      cyc();
      op1(3'd0, 16'h1111, 16'h2222);
      chk("t4_add", 32'(ALU_output), 32'h3333);
      chk("t4_done1", 32'(done), 32'd1);
      op1(3'd3, 16'h00F0, 16'h0F00);
      chk("t4_or", 32'(ALU_output), 32'h0FF0);
      chk("t4_done2", 32'(done), 32'd1);
      op1(3'd2, 16'hFF00, 16'h0FF0);
      chk("t4_and", 32'(ALU_output), 32'h0F00);
      chk("t4_done3", 32'(done), 32'd1);

      cyc(); op1(3'd7, 16'h0005, 16'h0006);
      repeat (8) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("t5_ready", 32'(ready), 32'd1);
      chk("t5_stall", 32'(stall), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      chk("t5_out", 32'(ALU_output), 32'd0);
      cyc();
      rst = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         chk("t5_nodone", 32'(done), 32'd0);
      end
      cyc(); op1(3'd0, 16'h0002, 16'h0003);
      chk("t5_add", 32'(ALU_output), 32'h0005);
      chk("t5_add_done", 32'(done), 32'd1);

      cyc(); op1(3'b101, 16'h1234, 16'h5678);
      chk("t6_done", 32'(done), 32'd1);
      chk("t6_out", 32'(ALU_output), 32'd0);
      chk("t6_zero", 32'(zero), 32'd1);
      chk("t6_ill", 32'(illegal), 32'd1);
      cyc(); op1(3'd2, 16'h00FF, 16'h0F0F);
      chk("t6_clear", 32'(illegal), 32'd0);
      chk("t6_and", 32'(ALU_output), 32'h000F);

      for (int i = 0; i < 1500; i++) begin
         cyc();
         start = ($urandom_range(0, 9) < 6);
         case ($urandom_range(0, 7))
            0: ALU_ctrl = 3'd7;
            1: ALU_ctrl = 3'($urandom_range(5, 6));
            default: ALU_ctrl = 3'($urandom_range(0, 4));
         endcase
         in0 = pick();
         in1 = pick();
         if ($urandom_range(0, 199) == 0) begin
            rst = 1'b1;
            #2;
            rst = 1'b0;
         end
      end
      cyc();
      start = 1'b0;
      repeat (20) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
